dff_bank_seq: RTL and testbench

- Sequencer and arbiter that shares one register bank of udp_dff-style cells (data input, active-low clr_, active-low set_) between NREQ requesters.
- Each request is one of: parallel load, asynchronous clear or asynchronous preset.
- Runs round-robin arbitration, then drives the bank's load enable or a timed clr_/set_ pulse, waits a recovery interval, and reports completion.

---
 rtl/dff_bank_seq_pkg.sv | 31 +++
 rtl/dff_bank_seq_if.sv | 41 ++++
 rtl/dff_bank_seq_rr_arbiter.sv | 61 ++++++
 rtl/dff_bank_seq.sv | 202 ++++++++++++++++++++
 tb/tb_dff_bank_seq.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dff_bank_seq_pkg.sv
// ----------------------------------------------------------------------------
// dff_bank_pkg
//   Shared definitions for the dff_bank_seq sequencer:
//     - request op encoding (load / clear / preset / reserved)
//     - sequencer state enum
//     - cnt_width(): width of the shared pulse/recovery down-counter
// ----------------------------------------------------------------------------
package dff_bank_pkg;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_CLR  = 2'b01;
   localparam logic [1:0] OP_SET  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_PULSE   = 3'd2,
      ST_RECOVER = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   // One counter serves both the pulse and the recovery phase, so it must
   // hold the larger of the two reload values.
   function automatic int cnt_width(input int pulse_cyc, input int hold_cyc);
      int m;
      m = (pulse_cyc > hold_cyc) ? pulse_cyc : hold_cyc;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/dff_bank_seq_if.sv
// ----------------------------------------------------------------------------
// dff_bank_seq_if
//   Bundles the requester handshake, the bank drive and the completion report
//   of dff_bank_seq.
//     req_valid/req_op/req_data : requester -> sequencer (packed per requester)
//     req_ready                 : sequencer -> requester accept strobe
//     bank_d/bank_load/bank_clr_/bank_set_ : sequencer -> register bank
//     busy/done_valid/done_id/err          : sequencer status / completion
//   master : requester/bank side (testbench), slave : the sequencer.
// ----------------------------------------------------------------------------
interface dff_bank_seq_if #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 2
) ();
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req_valid;
   logic [2*NREQ-1:0]     req_op;
   logic [WIDTH*NREQ-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic [WIDTH-1:0]      bank_d;
   logic                  bank_load;
   logic                  bank_clr_;
   logic                  bank_set_;
   logic                  busy;
   logic                  done_valid;
   logic [IDW-1:0]        done_id;
   logic                  err;

   modport master (
      output req_valid, req_op, req_data,
      input  req_ready, bank_d, bank_load, bank_clr_, bank_set_,
             busy, done_valid, done_id, err
   );

   modport slave (
      input  req_valid, req_op, req_data,
      output req_ready, bank_d, bank_load, bank_clr_, bank_set_,
             busy, done_valid, done_id, err
   );
endinterface

// File: rtl/dff_bank_seq_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter. Grant is purely combinational: the first valid
//   requester strictly after the last-granted index, wrapping. The
//   last-granted pointer is registered and loaded from upd_id when upd_en.
//   Ports:
//     clk, rst_ : clock, asynchronous active-low reset
//     valid     : request vector
//     upd_en    : load pointer with upd_id this cycle
//     upd_id    : index to record as last granted
//     grant     : one-hot (or zero) grant
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int NREQ = 2,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst_,
   input  logic [NREQ-1:0] valid,
   input  logic            upd_en,
   input  logic [IDW-1:0]  upd_id,
   output logic [NREQ-1:0] grant
);

   logic [IDW-1:0] last_q;
   logic [IDW-1:0] last_d;
   logic [IDW-1:0] idx;
   logic           found;

   always_comb begin
      last_d = last_q;
      if (upd_en) begin
         last_d = upd_id;
      end
   end

   // Reset to the highest index so requester 0 is first in line.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         last_q <= IDW'(NREQ - 1);
      end else begin
         last_q <= last_d;
      end
   end

   // Scan offsets 1..NREQ from the pointer; offset NREQ revisits the last
   // winner, so a lone requester is still served back to back.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(last_q) + k) % NREQ);
         if (!found && valid[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dff_bank_seq.sv
// ----------------------------------------------------------------------------
// dff_bank_seq
//   Shares one register bank of D/clr_/set_ cells between NREQ requesters.
//   Arbitrates round-robin, then either pulses bank_load for one cycle
//   (load), holds bank_clr_ or bank_set_ low for PULSE_CYC cycles followed by
//   HOLD_CYC recovery cycles (clear / preset), or completes immediately with
//   err (reserved op). Completion is a one-cycle done_valid with done_id.
//   Ports:
//     clk  : clock
//     rst_ : asynchronous active-low reset (releases clr_/set_ at once)
//     bus  : dff_bank_seq_if.slave (requests, bank drive, status)
//   All outputs are registered except req_ready.
// ----------------------------------------------------------------------------
module dff_bank_seq
   import dff_bank_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int NREQ      = 2,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic          clk,
   input  logic          rst_,
   dff_bank_seq_if.slave bus
);

   localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = cnt_width(PULSE_CYC, HOLD_CYC);
   localparam logic [CNT_W-1:0] PULSE_INIT = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_INIT  = (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : '0;

   // FSM state and captured request
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [IDW-1:0]   id_q, id_d;

   // Registered outputs
   logic [WIDTH-1:0] bank_d_q, bank_d_d;
   logic             bank_load_q, bank_load_d;
   logic             bank_clr_n_q, bank_clr_n_d;
   logic             bank_set_n_q, bank_set_n_d;
   logic             busy_q, busy_d;
   logic             done_valid_q, done_valid_d;
   logic [IDW-1:0]   done_id_q, done_id_d;
   logic             err_q, err_d;

   logic [NREQ-1:0]  grant;
   logic             upd_en;
   logic [1:0]       op_arr   [NREQ];
   logic [WIDTH-1:0] data_arr [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign op_arr[gi]   = bus.req_op[2*gi +: 2];
         assign data_arr[gi] = bus.req_data[WIDTH*gi +: WIDTH];
      end
   endgenerate

   // Pointer moves to the served requester as the op completes.
   assign upd_en = (state_q == ST_DONE);

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .clk    (clk),
      .rst_   (rst_),
      .valid  (bus.req_valid),
      .upd_en (upd_en),
      .upd_id (id_q),
      .grant  (grant)
   );

   assign bus.req_ready = (state_q == ST_IDLE) ? grant : '0;

   // ---------------- register process ----------------
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         op_q         <= OP_LOAD;
         data_q       <= '0;
         id_q         <= '0;
         bank_d_q     <= '0;
         bank_load_q  <= 1'b0;
         bank_clr_n_q <= 1'b1;
         bank_set_n_q <= 1'b1;
         busy_q       <= 1'b0;
         done_valid_q <= 1'b0;
         done_id_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_q         <= op_d;
         data_q       <= data_d;
         id_q         <= id_d;
         bank_d_q     <= bank_d_d;
         bank_load_q  <= bank_load_d;
         bank_clr_n_q <= bank_clr_n_d;
         bank_set_n_q <= bank_set_n_d;
         busy_q       <= busy_d;
         done_valid_q <= done_valid_d;
         done_id_q    <= done_id_d;
         err_q        <= err_d;
      end
   end

   // ---------------- next-state process ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      data_d  = data_q;
      id_d    = id_q;
      case (state_q)
         ST_IDLE: begin
            if (|grant) begin
               for (int i = 0; i < NREQ; i++) begin
                  if (grant[i]) begin
                     op_d   = op_arr[i];
                     data_d = data_arr[i];
                     id_d   = IDW'(i);
                  end
               end
               case (op_d)
                  OP_LOAD: state_d = ST_LOAD;
                  OP_CLR,
                  OP_SET: begin
                     state_d = ST_PULSE;
                     cnt_d   = PULSE_INIT;
                  end
                  default: state_d = ST_DONE;
               endcase
            end
         end
         ST_LOAD: state_d = ST_DONE;
         ST_PULSE: begin
            if (cnt_q == '0) begin
               if (HOLD_CYC == 0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RECOVER;
                  cnt_d   = HOLD_INIT;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RECOVER: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- output process ----------------
   // Outputs are decoded from the *next* state so that, once registered,
   // they line up with the cycle the FSM actually spends in that state.
   always_comb begin
      bank_d_d     = bank_d_q;
      bank_load_d  = 1'b0;
      bank_clr_n_d = 1'b1;
      bank_set_n_d = 1'b1;
      busy_d       = (state_d != ST_IDLE);
      done_valid_d = 1'b0;
      done_id_d    = done_id_q;
      err_d        = 1'b0;
      case (state_d)
         ST_LOAD: begin
            bank_load_d = 1'b1;
            bank_d_d    = data_d;
         end
         ST_PULSE: begin
            bank_clr_n_d = (op_d != OP_CLR);
            bank_set_n_d = (op_d != OP_SET);
         end
         ST_DONE: begin
            done_valid_d = 1'b1;
            done_id_d    = id_d;
            err_d        = (op_d == OP_RSVD);
         end
         default: ;
      endcase
   end

   assign bus.bank_d     = bank_d_q;
   assign bus.bank_load  = bank_load_q;
   assign bus.bank_clr_  = bank_clr_n_q;
   assign bus.bank_set_  = bank_set_n_q;
   assign bus.busy       = busy_q;
   assign bus.done_valid = done_valid_q;
   assign bus.done_id    = done_id_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_dff_bank_seq.sv
// ----------------------------------------------------------------------------
// tb_dff_bank_seq
//   Two sequencer instances: dut_a (PULSE_CYC=2, HOLD_CYC=1) and dut_b
//   (PULSE_CYC=1, HOLD_CYC=0). Directed scenarios plus a randomized run on
//   dut_a checked against a cycle-timeline model of the request lifecycle.
// ----------------------------------------------------------------------------
module tb_dff_bank_seq;
   import dff_bank_pkg::*;

   localparam int WIDTH = 8;
   localparam int NREQ  = 2;
   localparam int PA    = 2;
   localparam int HA    = 1;
   localparam int PB    = 1;
   localparam int HB    = 0;

   logic clk  = 1'b0;
   logic rst_ = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   dff_bank_seq_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus_a ();
   dff_bank_seq_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus_b ();

   dff_bank_seq #(.WIDTH(WIDTH), .NREQ(NREQ), .PULSE_CYC(PA), .HOLD_CYC(HA)) dut_a (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus_a)
   );

   dff_bank_seq #(.WIDTH(WIDTH), .NREQ(NREQ), .PULSE_CYC(PB), .HOLD_CYC(HB)) dut_b (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus_b)
   );

   task automatic idle_inputs();
      bus_a.req_valid = '0;
      bus_a.req_op    = '0;
      bus_a.req_data  = '0;
      bus_b.req_valid = '0;
      bus_b.req_op    = '0;
      bus_b.req_data  = '0;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      logic [WIDTH+6:0] exp_v;
      rst_ = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      // {clr_, set_, load, done, err, busy, done_id, bank_d}
      exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      n_checks++;
      if ({bus_a.bank_clr_, bus_a.bank_set_, bus_a.bank_load, bus_a.done_valid, bus_a.err,
           bus_a.busy, bus_a.done_id, bus_a.bank_d} !== exp_v) begin
         n_fail++;
         $display("FAIL reset_a: outputs=%h expected %h", {bus_a.bank_clr_, bus_a.bank_set_,
                  bus_a.bank_load, bus_a.done_valid, bus_a.err, bus_a.busy, bus_a.done_id, bus_a.bank_d}, exp_v);
      end
      n_checks++;
      if ({bus_b.bank_clr_, bus_b.bank_set_, bus_b.bank_load, bus_b.done_valid, bus_b.err,
           bus_b.busy, bus_b.done_id, bus_b.bank_d} !== exp_v) begin
         n_fail++;
         $display("FAIL reset_b: outputs=%h expected %h", {bus_b.bank_clr_, bus_b.bank_set_,
                  bus_b.bank_load, bus_b.done_valid, bus_b.err, bus_b.busy, bus_b.done_id, bus_b.bank_d}, exp_v);
      end
      rst_ = 1'b1;
   endtask

   // ------------------------------------------------------------------
   task automatic test_load();
      @(negedge clk);
      bus_a.req_valid = 2'b01;
      bus_a.req_op    = {OP_LOAD, OP_LOAD};
      bus_a.req_data  = {8'h3C, 8'hA5};
      #1;
      n_checks++;
      if (bus_a.req_ready !== 2'b01) begin
         n_fail++; $display("FAIL load_ready: req_ready=%b expected 01", bus_a.req_ready);
      end
      @(negedge clk);
      bus_a.req_valid = '0;
      #1;
      n_checks++;
      if ({bus_a.bank_load, bus_a.bank_d, bus_a.done_valid, bus_a.busy} !== {1'b1, 8'hA5, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL load_t1: load=%b d=%h done=%b busy=%b expected 1 a5 0 1",
                            bus_a.bank_load, bus_a.bank_d, bus_a.done_valid, bus_a.busy);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus_a.done_valid, bus_a.done_id, bus_a.err, bus_a.bank_load} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL load_done: done=%b id=%0d err=%b load=%b expected 1 0 0 0",
                            bus_a.done_valid, bus_a.done_id, bus_a.err, bus_a.bank_load);
      end
      $display("txn load id=0 data=a5");
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus_a.done_valid, bus_a.busy, bus_a.bank_d} !== {1'b0, 1'b0, 8'hA5}) begin
         n_fail++; $display("FAIL load_after: done=%b busy=%b d=%h expected 0 0 a5",
                            bus_a.done_valid, bus_a.busy, bus_a.bank_d);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_clear();
      logic exp_clr, exp_done;
      @(negedge clk);
      bus_a.req_valid = 2'b10;
      bus_a.req_op    = {OP_CLR, OP_LOAD};
      bus_a.req_data  = 16'($urandom);
      #1;
      n_checks++;
      if (bus_a.req_ready !== 2'b10) begin
         n_fail++; $display("FAIL clr_ready: req_ready=%b expected 10", bus_a.req_ready);
      end
      for (int k = 1; k <= PA + HA + 1; k++) begin
         @(negedge clk);
         bus_a.req_valid = '0;
         #1;
         exp_clr  = !(k <= PA);
         exp_done = (k == PA + HA + 1);
         n_checks++;
         if ({bus_a.bank_clr_, bus_a.bank_set_, bus_a.done_valid, bus_a.busy} !== {exp_clr, 1'b1, exp_done, 1'b1}) begin
            n_fail++; $display("FAIL clr_t%0d: clr_=%b set_=%b done=%b busy=%b expected %b 1 %b 1", k,
                               bus_a.bank_clr_, bus_a.bank_set_, bus_a.done_valid, bus_a.busy, exp_clr, exp_done);
         end
      end
      n_checks++;
      if (bus_a.done_id !== 1'b1) begin
         n_fail++; $display("FAIL clr_id: done_id=%0d expected 1", bus_a.done_id);
      end
      $display("txn clear id=1");
   endtask

   // ------------------------------------------------------------------
   task automatic test_back_to_back();
      int          exp_grant;
      int          grants_seen;
      int          dones_seen;
      int          set_low_cycles;
      int          order_q[$];
      int          exp_id;
      logic [NREQ-1:0] exp_rdy;
      exp_grant      = 0;
      grants_seen    = 0;
      dones_seen     = 0;
      set_low_cycles = 0;
      @(negedge clk);
      bus_a.req_valid = 2'b11;
      bus_a.req_op    = {OP_SET, OP_SET};
      bus_a.req_data  = 16'($urandom);
      for (int cyc = 0; cyc < 60 && dones_seen < 4; cyc++) begin
         if (cyc != 0) @(negedge clk);
         if (grants_seen >= 4) bus_a.req_valid = '0;
         #1;
         n_checks++;
         if ($countones(bus_a.req_ready) > 1) begin
            n_fail++; $display("FAIL b2b_onehot: req_ready=%b expected at most one bit", bus_a.req_ready);
         end
         n_checks++;
         if ((!bus_a.bank_clr_ && !bus_a.bank_set_) || (bus_a.bank_load && (!bus_a.bank_clr_ || !bus_a.bank_set_))) begin
            n_fail++; $display("FAIL b2b_excl: clr_=%b set_=%b load=%b expected mutually exclusive",
                               bus_a.bank_clr_, bus_a.bank_set_, bus_a.bank_load);
         end
         if (!bus_a.bank_set_) set_low_cycles++;
         if (bus_a.req_ready != '0) begin
            exp_rdy = '0;
            exp_rdy[exp_grant] = 1'b1;
            n_checks++;
            if (bus_a.req_ready !== exp_rdy) begin
               n_fail++; $display("FAIL b2b_grant%0d: req_ready=%b expected %b", grants_seen, bus_a.req_ready, exp_rdy);
            end
            order_q.push_back(exp_grant);
            exp_grant = (exp_grant + 1) % NREQ;
            grants_seen++;
         end
         if (bus_a.done_valid === 1'b1) begin
            exp_id = (order_q.size() > 0) ? order_q.pop_front() : -1;
            n_checks++;
            if (int'(bus_a.done_id) != exp_id) begin
               n_fail++; $display("FAIL b2b_done%0d: done_id=%0d expected %0d", dones_seen, bus_a.done_id, exp_id);
            end
            $display("txn preset id=%0d", bus_a.done_id);
            dones_seen++;
         end
      end
      bus_a.req_valid = '0;
      n_checks++;
      if (dones_seen != 4) begin
         n_fail++; $display("FAIL b2b_count: dones=%0d expected 4 within cycle budget", dones_seen);
      end
      n_checks++;
      if (set_low_cycles != 4 * PA) begin
         n_fail++; $display("FAIL b2b_setlow: set_ low cycles=%0d expected %0d", set_low_cycles, 4 * PA);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_reserved();
      @(negedge clk);
      bus_a.req_valid = 2'b01;
      bus_a.req_op    = {OP_LOAD, OP_RSVD};
      bus_a.req_data  = {8'h00, 8'h5A};
      #1;
      n_checks++;
      if (bus_a.req_ready !== 2'b01) begin
         n_fail++; $display("FAIL rsvd_ready: req_ready=%b expected 01", bus_a.req_ready);
      end
      @(negedge clk);
      bus_a.req_valid = '0;
      #1;
      n_checks++;
      if ({bus_a.done_valid, bus_a.err, bus_a.done_id, bus_a.bank_load, bus_a.bank_clr_, bus_a.bank_set_, bus_a.bank_d}
          !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5}) begin
         n_fail++; $display("FAIL rsvd_done: done=%b err=%b id=%0d load=%b clr_=%b set_=%b d=%h expected 1 1 0 0 1 1 a5",
                            bus_a.done_valid, bus_a.err, bus_a.done_id, bus_a.bank_load,
                            bus_a.bank_clr_, bus_a.bank_set_, bus_a.bank_d);
      end
      $display("txn reserved id=0 err=%b", bus_a.err);
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus_a.done_valid, bus_a.err, bus_a.busy} !== 3'b000) begin
         n_fail++; $display("FAIL rsvd_after: done=%b err=%b busy=%b expected 0 0 0",
                            bus_a.done_valid, bus_a.err, bus_a.busy);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset_mid_pulse();
      int stray_done;
      stray_done = 0;
      @(negedge clk);
      bus_a.req_valid = 2'b10;
      bus_a.req_op    = {OP_SET, OP_LOAD};
      #1;
      n_checks++;
      if (bus_a.req_ready !== 2'b10) begin
         n_fail++; $display("FAIL rmp_ready: req_ready=%b expected 10", bus_a.req_ready);
      end
      @(negedge clk);
      bus_a.req_valid = '0;
      #1;
      n_checks++;
      if (bus_a.bank_set_ !== 1'b0) begin
         n_fail++; $display("FAIL rmp_pulse: set_=%b expected 0", bus_a.bank_set_);
      end
      rst_ = 1'b0;
      #1;
      n_checks++;
      if ({bus_a.bank_set_, bus_a.bank_clr_, bus_a.busy} !== 3'b110) begin
         n_fail++; $display("FAIL rmp_async: set_=%b clr_=%b busy=%b expected 1 1 0",
                            bus_a.bank_set_, bus_a.bank_clr_, bus_a.busy);
      end
      @(negedge clk);
      rst_ = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #1;
         if (bus_a.done_valid !== 1'b0) stray_done++;
      end
      n_checks++;
      if (stray_done != 0) begin
         n_fail++; $display("FAIL rmp_nodone: done pulses=%0d expected 0", stray_done);
      end
      @(negedge clk);
      bus_a.req_valid = 2'b11;
      bus_a.req_op    = {OP_LOAD, OP_LOAD};
      #1;
      n_checks++;
      if (bus_a.req_ready !== 2'b01) begin
         n_fail++; $display("FAIL rmp_first: req_ready=%b expected 01", bus_a.req_ready);
      end
      bus_a.req_valid = '0;   // withdrawn before the edge: no transfer
   endtask

   // ------------------------------------------------------------------
   task automatic test_short_pulse();
      logic exp_clr, exp_done;
      @(negedge clk);
      bus_b.req_valid = 2'b01;
      bus_b.req_op    = {OP_LOAD, OP_CLR};
      #1;
      n_checks++;
      if (bus_b.req_ready !== 2'b01) begin
         n_fail++; $display("FAIL short_ready: req_ready=%b expected 01", bus_b.req_ready);
      end
      for (int k = 1; k <= PB + HB + 2; k++) begin
         @(negedge clk);
         bus_b.req_valid = '0;
         #1;
         exp_clr  = !(k <= PB);
         exp_done = (k == PB + HB + 1);
         n_checks++;
         if ({bus_b.bank_clr_, bus_b.bank_set_, bus_b.done_valid} !== {exp_clr, 1'b1, exp_done}) begin
            n_fail++; $display("FAIL short_t%0d: clr_=%b set_=%b done=%b expected %b 1 %b", k,
                               bus_b.bank_clr_, bus_b.bank_set_, bus_b.done_valid, exp_clr, exp_done);
         end
      end
      $display("txn short-clear id=0");
   endtask

   // ------------------------------------------------------------------
   // Model: each accepted op occupies a fixed window of cycles measured from
   // its accept cycle; arbitration picks the first valid after the last
   // served requester.
   task automatic test_random(input int ncyc);
      logic            v    [NREQ];
      logic [1:0]      o    [NREQ];
      logic [WIDTH-1:0] d   [NREQ];
      logic            xfer [NREQ];
      int              m_last, m_t, m_done, m_id, win, j;
      logic [1:0]      m_op;
      logic [WIDTH-1:0] m_data, m_bank;
      logic [NREQ-1:0] exp_rdy;
      logic exp_load, exp_clr, exp_set, exp_done, exp_err, exp_busy;
      rst_ = 1'b0;
      idle_inputs();
      @(negedge clk);
      rst_ = 1'b1;
      m_last = NREQ - 1; m_t = -100; m_done = -100; m_id = 0;
      m_op = OP_LOAD; m_data = '0; m_bank = '0;
      for (int i = 0; i < NREQ; i++) begin
         v[i] = 1'b0; o[i] = 2'b00; d[i] = '0; xfer[i] = 1'b0;
      end
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (!v[i] || xfer[i]) begin
               v[i] = ($urandom_range(0, 2) != 0);
               o[i] = 2'($urandom_range(0, 3));
               d[i] = WIDTH'($urandom);
            end
            bus_a.req_valid[i]              = v[i];
            bus_a.req_op[2*i +: 2]          = o[i];
            bus_a.req_data[WIDTH*i +: WIDTH] = d[i];
         end
         #1;
         win = -1;
         exp_rdy = '0;
         if (c > m_done) begin
            for (int k = 1; k <= NREQ; k++) begin
               j = (m_last + k) % NREQ;
               if (win < 0 && v[j]) win = j;
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
         end
         exp_load = (m_op == OP_LOAD) && (c == m_t + 1);
         exp_clr  = !((m_op == OP_CLR) && (c >= m_t + 1) && (c <= m_t + PA));
         exp_set  = !((m_op == OP_SET) && (c >= m_t + 1) && (c <= m_t + PA));
         exp_done = (c == m_done);
         exp_err  = exp_done && (m_op == OP_RSVD);
         exp_busy = (c > m_t) && (c <= m_done);
         if (exp_load) m_bank = m_data;
         n_checks++;
         if ({bus_a.req_ready, bus_a.bank_load, bus_a.bank_clr_, bus_a.bank_set_, bus_a.done_valid,
              bus_a.err, bus_a.busy, bus_a.bank_d} !==
             {exp_rdy, exp_load, exp_clr, exp_set, exp_done, exp_err, exp_busy, m_bank}) begin
            n_fail++;
            $display("FAIL rand_c%0d: rdy=%b load=%b clr_=%b set_=%b done=%b err=%b busy=%b d=%h expected %b %b %b %b %b %b %b %h",
                     c, bus_a.req_ready, bus_a.bank_load, bus_a.bank_clr_, bus_a.bank_set_, bus_a.done_valid,
                     bus_a.err, bus_a.busy, bus_a.bank_d, exp_rdy, exp_load, exp_clr, exp_set, exp_done,
                     exp_err, exp_busy, m_bank);
         end
         if (exp_done) begin
            n_checks++;
            if (int'(bus_a.done_id) != m_id) begin
               n_fail++; $display("FAIL rand_id_c%0d: done_id=%0d expected %0d", c, bus_a.done_id, m_id);
            end
            $display("txn rand id=%0d op=%0d data=%h", m_id, m_op, m_data);
         end
         for (int i = 0; i < NREQ; i++) xfer[i] = v[i] && exp_rdy[i];
         if (win >= 0) begin
            m_t    = c;
            m_op   = o[win];
            m_data = d[win];
            m_id   = win;
            m_last = win;
            case (m_op)
               OP_LOAD: m_done = c + 2;
               OP_RSVD: m_done = c + 1;
               default: m_done = c + PA + HA + 1;
            endcase
         end
      end
      bus_a.req_valid = '0;
   endtask

   // ------------------------------------------------------------------
   initial begin
      idle_inputs();
      test_reset();
      test_load();
      test_clear();
      test_back_to_back();
      test_reserved();
      test_reset_mid_pulse();
      test_short_pulse();
      test_random(400);
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
